// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the execute-stage control and
// the multi-cycle ALU.
//   start/op/a/b             : request, driven by the master (control unit)
//   result/hi/zout/ovf       : registered results, driven by the ALU
//   busy/done                : handshake status, driven by the ALU
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic             zout;
   logic             ovf;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a, b,
      input  result, hi, zout, ovf, busy, done
   );

   modport slave (
      input  start, op, a, b,
      output result, hi, zout, ovf, busy, done
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU for the execute stage.
// Single-cycle logic/arith/shift ops finish one edge after accept; MULTU and
// DIVU iterate one bit per edge for WIDTH edges. All outputs are registered
// and hold until the next completion.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : alu_mc_if.slave (start/op/a/b in; result/hi/zout/ovf/busy/done out)
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic    clk,
   input  logic    reset,
   alu_mc_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
   localparam logic [3:0] OP_MULU = 4'b1010;
   localparam logic [3:0] OP_DIVU = 4'b1011;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;        // MUL: {acc_hi, multiplier}; DIV: {rem, quotient}
   logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand or divisor
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic               zout_q, zout_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // single-cycle datapath
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] add_s, sub_s, sc_res;
   logic             ovf_add, ovf_sub, sc_ovf;

   always_comb begin
      sh      = bus.a[SHW-1:0];
      add_s   = bus.a + bus.b;
      sub_s   = bus.a + ~bus.b + 1'b1;
      ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
      ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
      sc_res  = '0;
      sc_ovf  = 1'b0;
      case (bus.op)
         OP_AND: sc_res = bus.a & bus.b;
         OP_OR:  sc_res = bus.a | bus.b;
         OP_ADD: begin sc_res = add_s; sc_ovf = ovf_add; end
         OP_SLL: sc_res = bus.b << sh;
         OP_NOR: sc_res = ~(bus.a | bus.b);
         OP_SUB: begin sc_res = sub_s; sc_ovf = ovf_sub; end
         // true signed compare: sign of the difference corrected by overflow
         OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ ovf_sub};
         OP_SRL: sc_res = bus.b >> sh;
         OP_SRA: sc_res = $unsigned($signed(bus.b) >>> sh);
         default: ;
      endcase
   end

   // iterative step datapath
   logic [WIDTH:0]     mul_sum, div_sh, div_dif;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, it_nxt;

   always_comb begin
      // shift-add: add multiplicand into upper half on multiplier LSB, then shift right
      mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? opnd_q : {WIDTH{1'b0}})};
      mul_nxt = {mul_sum, p_q[WIDTH-1:1]};
      // restoring divide: shift next dividend bit into remainder, try subtract
      div_sh  = p_q[2*WIDTH-1:WIDTH-1];
      div_dif = div_sh - {1'b0, opnd_q};
      // b==0 always "subtracts" zero: quotient all ones, remainder collects a
      div_ge  = (opnd_q == '0) || !div_dif[WIDTH];
      div_nxt = div_ge ? {div_dif[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1}
                       : {div_sh[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b0};
      it_nxt  = (state_q == S_MUL) ? mul_nxt : div_nxt;
   end

   // next-state
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      hi_d     = hi_q;
      zout_d   = zout_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.op == OP_MULU) begin
                  state_d = S_MUL;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  p_d     = {{WIDTH{1'b0}}, bus.b};
                  opnd_d  = bus.a;
               end else if (bus.op == OP_DIVU) begin
                  state_d = S_DIV;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  p_d     = {{WIDTH{1'b0}}, bus.a};
                  opnd_d  = bus.b;
               end else begin
                  result_d = sc_res;
                  hi_d     = '0;
                  zout_d   = (sc_res == '0);
                  ovf_d    = sc_ovf;
                  done_d   = 1'b1;
               end
            end
         end
         S_MUL, S_DIV: begin
            p_d   = it_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d  = S_IDLE;
               cnt_d    = '0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               result_d = it_nxt[WIDTH-1:0];
               hi_d     = it_nxt[2*WIDTH-1:WIDTH];
               zout_d   = (it_nxt[WIDTH-1:0] == '0);
               ovf_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         p_q      <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         hi_q     <= '0;
         zout_q   <= 1'b1;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         zout_q   <= zout_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.result = result_q;
   assign bus.hi     = hi_q;
   assign bus.zout   = zout_q;
   assign bus.ovf    = ovf_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc (WIDTH=32). A transaction-level
// model predicts every output on every cycle; literal expectations pin both
// the model and the DUT on the directed vectors.
module tb_alu_mc;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_mc_if #(.WIDTH(W)) bus ();
   alu_mc #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // returns {ovf, hi, result}
   function automatic logic [64:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r, h;
      logic [63:0] prod;
      logic        ov;
      r = '0; h = '0; ov = 1'b0;
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd3:  r = b << a[4:0];
         4'd4:  r = ~(a | b);
         4'd6:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8:  r = b >> a[4:0];
         4'd9:  r = $signed(b) >>> a[4:0];
         4'd10: begin prod = 64'(a) * 64'(b); r = prod[31:0]; h = prod[63:32]; end
         4'd11: begin
            if (b == 0) begin r = 32'hFFFF_FFFF; h = a; end
            else begin r = a / b; h = a % b; end
         end
         default: ;
      endcase
      return {ov, h, r};
   endfunction

   logic [31:0] m_result, m_hi, p_res, p_hi;
   logic        m_zout, m_ovf, m_busy, m_done;
   int          pend;
   logic [64:0] mv;

   always @(posedge clk) begin
      if (reset) begin
         m_result <= '0; m_hi <= '0; m_zout <= 1'b1; m_ovf <= 1'b0;
         m_busy <= 1'b0; m_done <= 1'b0; pend <= 0;
      end else begin
         m_done <= 1'b0;
         if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
               m_result <= p_res; m_hi <= p_hi; m_zout <= (p_res == 0);
               m_ovf <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
            end
         end else if (bus.start) begin
            mv = model(bus.op, bus.a, bus.b);
            if (bus.op == 4'd10 || bus.op == 4'd11) begin
               pend <= W; m_busy <= 1'b1;
               p_res <= mv[31:0]; p_hi <= mv[63:32];
            end else begin
               m_result <= mv[31:0]; m_hi <= mv[63:32]; m_zout <= (mv[31:0] == 0);
               m_ovf <= mv[64]; m_done <= 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_busy",   bus.busy,   m_busy);
         chk("cyc_done",   bus.done,   m_done);
         chk("cyc_result", bus.result, m_result);
         chk("cyc_hi",     bus.hi,     m_hi);
         chk("cyc_zout",   bus.zout,   m_zout);
         chk("cyc_ovf",    bus.ovf,    m_ovf);
      end
   end

   // ---------------- directed stimulus ----------------
   int bc;

   // pokes a stray ADD start during busy when poke_at >= 0
   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int poke_at, output int busy_cyc);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      @(negedge clk);
      bus.start = 1'b0;
      busy_cyc = 0;
      for (int i = 0; i < 40 && !bus.done; i++) begin
         if (bus.busy) busy_cyc++;
         if (i == poke_at) begin bus.start = 1'b1; bus.op = 4'd2; bus.a = 32'd1; bus.b = 32'd1; end
         else begin bus.start = 1'b0; bus.a = 32'hDEAD_BEEF; end
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("done_seen", bus.done, 1'b1);
   endtask

   task automatic lit(input string nm, input logic [31:0] r, input logic [31:0] h);
      chk({nm, "_res"},   bus.result, r);
      chk({nm, "_hi"},    bus.hi,     h);
      chk({nm, "_model"}, m_result,   r);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_zout",   bus.zout,   1'b1);
      chk("rst_busy",   bus.busy,   1'b0);
      chk("rst_done",   bus.done,   1'b0);
      reset = 1'b0;

      run_op(4'd2, 32'h7FFF_FFFF, 32'd1, -1, bc);
      lit("add_ovf", 32'h8000_0000, 32'd0);
      chk("add_ovf_flag", bus.ovf, 1'b1);
      chk("add_zout", bus.zout, 1'b0);
      chk("add_busy", bc, 0);

      run_op(4'd6, 32'd5, 32'd5, -1, bc);
      lit("sub_eq", 32'd0, 32'd0);
      chk("sub_zout", bus.zout, 1'b1);
      chk("sub_ovf",  bus.ovf,  1'b0);

      run_op(4'd7, 32'hFFFF_FFFF, 32'd1, -1, bc);          lit("slt_neg", 32'd1, 32'd0);
      run_op(4'd7, 32'h8000_0000, 32'h7FFF_FFFF, -1, bc);  lit("slt_ext", 32'd1, 32'd0);
      run_op(4'd7, 32'h7FFF_FFFF, 32'h8000_0000, -1, bc);  lit("slt_rev", 32'd0, 32'd0);
      run_op(4'd4, 32'd0, 32'd0, -1, bc);                  lit("nor",     32'hFFFF_FFFF, 32'd0);
      run_op(4'd9, 32'd4, 32'hF000_0000, -1, bc);          lit("sra",     32'hFF00_0000, 32'd0);
      run_op(4'd8, 32'd4, 32'hF000_0000, -1, bc);          lit("srl",     32'h0F00_0000, 32'd0);
      run_op(4'd3, 32'd36, 32'd1, -1, bc);                 lit("sll",     32'h0000_0010, 32'd0);
      run_op(4'd5, 32'd3, 32'd3, -1, bc);                  lit("undef",   32'd0, 32'd0);

      // back-to-back single-cycle ops: done stays high
      @(negedge clk);
      bus.start = 1'b1; bus.op = 4'd0; bus.a = 32'hF0F0; bus.b = 32'hFF00;
      @(negedge clk);
      chk("b2b_and", bus.result, 32'hF000);
      bus.op = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_or",   bus.result, 32'hFFF0);
      chk("b2b_done", bus.done,   1'b1);

      run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, bc);
      lit("multu", 32'h0000_0001, 32'hFFFF_FFFE);
      chk("multu_busy_cyc", bc, 32);
      @(negedge clk);
      chk("multu_single_done", bus.done, 1'b0);

      run_op(4'd11, 32'd100, 32'd7, -1, bc);  lit("divu",   32'd14, 32'd2);
      chk("divu_busy_cyc", bc, 32);
      run_op(4'd11, 32'd9, 32'd0, -1, bc);    lit("divu_0", 32'hFFFF_FFFF, 32'd9);
      run_op(4'd10, 32'd12345, 32'd678, -1, bc);
      lit("multu_small", 32'd8369910, 32'd0);

      // reset mid MULTU aborts it
      @(negedge clk);
      bus.start = 1'b1; bus.op = 4'd10; bus.a = 32'd3; bus.b = 32'd4;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1; bus.start = 1'b1; bus.op = 4'd2;
      @(negedge clk);
      reset = 1'b0; bus.start = 1'b0;
      chk("abort_busy",   bus.busy,   1'b0);
      chk("abort_result", bus.result, 32'd0);
      chk("abort_zout",   bus.zout,   1'b1);
      chk("abort_done",   bus.done,   1'b0);
      repeat (3) @(negedge clk);
      run_op(4'd2, 32'd2, 32'd3, -1, bc);
      lit("add_after", 32'd5, 32'd0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, successor to the single-cycle 32-bit datapath ALU. All existing 3-bit operations are kept bit-compatible, NOR now yields the full width, and SRL/SRA plus iterative unsigned multiply and divide are added. Results, zero flag and overflow are registered, and a start/busy/done handshake lets the control unit stall on long operations. It sits in the execute stage between the register-file read ports and the write-back mux; HI/LO-style results leave on `result` and `hi`.

## Interface
- `WIDTH`, default 32: operand/result width; must be ≥ 8 and a power of two.
- `SHW`, default $clog2(WIDTH): shift-amount bits taken from `a`.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; sampled only on the `clk` rising edge
- `start`  in  1  request; accepted on an edge where `start`=1 and `busy`=0
- `op`  in  4  operation code (below)
- `a`, `b`  in  WIDTH  operands; captured at accept
- `result`  out  WIDTH  main result / product low half / quotient
- `hi`  out  WIDTH  product high half / remainder; 0 for other ops
- `zout`  out  1  1 when `result`==0, registered with `result`
- `ovf`  out  1  signed overflow for ADD/SUB, else 0
- `busy`  out  1  iterative op in progress
- `done`  out  1  one-cycle pulse: outputs updated this cycle

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL (b << a[SHW-1:0]), 0100 NOR (full width), 0110 SUB (a+~b+1), 0111 SLT (signed a<b → 1 else 0), 1000 SRL (b >> a[SHW-1:0]), 1001 SRA (arithmetic), 1010 MULTU, 1011 DIVU; all others give result=0, hi=0, ovf=0, done still pulses.
- ADD/SUB/SLT wrap modulo 2^WIDTH. `ovf` = operand sign rule (ADD: a,b same sign, sum differs; SUB: a,b differ in sign, diff sign ≠ a). SLT uses the true signed comparison (sign of difference XOR overflow).
- States: IDLE, MUL, DIV. An iteration counter runs from 0 to WIDTH-1.
- IDLE + accept of a single-cycle op: result/hi/zout/ovf are registered on the accept edge, done=1 for the following cycle, and the block stays in IDLE.
- IDLE + accept of MULTU: a and b are latched, the product accumulator is cleared, and the block goes to MUL. Each edge performs one shift-add step on the LSB of the multiplier. After WIDTH steps: {hi,result} = a*b (unsigned, 2·WIDTH bits), state goes to IDLE, done=1.
- DIVU: a restoring shift-subtract step per edge, WIDTH steps, then result = a/b and hi = a%b. When b==0: result = all ones and hi = a, with the same latency and no error flag.
- `start` while busy is ignored; it does not queue. `a`, `b` and `op` changes while busy have no effect.
- `reset`: state→IDLE, counter=0, result=0, hi=0, zout=1, ovf=0, busy=0, done=0. Reset mid-operation aborts the operation and produces no done pulse.
- Outputs hold their last value until the next completion.

## Timing
- Single-cycle ops have a latency of 1 edge. Accept at edge k gives done=1 and new outputs in the cycle after edge k. `busy` stays 0.
- MULTU/DIVU accepted at edge k: busy=1 after edges k .. k+WIDTH-1. Steps occur at edges k+1 .. k+WIDTH. After edge k+WIDTH: busy=0, done=1, results valid. Total latency is WIDTH+1 edges from accept.
- Back-to-back: a new start may be accepted on the edge that ends the done cycle (busy=0 then). Done stays high for consecutive single-cycle ops.
- `zout` and `ovf` change only on the same edges as `result`.
- `reset` asserted together with `start` takes priority: the request is dropped.

## Test plan
- Reset, then ADD a=0x7FFFFFFF, b=1 → after 1 edge result=0x80000000, ovf=1, zout=0, done pulse, busy=0.
- SUB a=5, b=5 → result=0, zout=1, ovf=0. SLT a=0xFFFFFFFF, b=1 → result=1. SLT a=0x80000000, b=0x7FFFFFFF → result=1.
- NOR a=0, b=0 → result=0xFFFFFFFF. SRA a=4, b=0xF0000000 → 0xFF000000. SRL with the same operands → 0x0F000000.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → busy for exactly 32 cycles, then hi=0xFFFFFFFE, result=0x00000001, and a single done pulse. A start pulse during busy is ignored.
- DIVU a=100, b=7 → result=14, hi=2 after 33 edges. DIVU b=0, a=9 → result=0xFFFFFFFF, hi=9.
- Assert reset at cycle 10 of a MULTU → busy=0, result=0, zout=1, no done. A following ADD 2+3 yields 5 on the next edge.
